// File: rtl/audio_voice_mixer_scheduler.sv
// Frame scheduler for the Audio_Controller write port: gathers one sample per voice,
// mixes, scales and saturates the sum, then issues a single write strobe per frame.
module audio_voice_mixer_scheduler #(
   parameter int NUM_VOICES       = 4,
   parameter int AUDIO_DATA_WIDTH = 21,
   parameter int ACC_WIDTH        = 23
) (
   input  logic                                   CLOCK_50,
   input  logic                                   reset,
   input  logic [NUM_VOICES-1:0]                  voice_enable,
   input  logic [NUM_VOICES-1:0]                  voice_valid,
   input  logic [NUM_VOICES*AUDIO_DATA_WIDTH-1:0] voice_sample,
   output logic [NUM_VOICES-1:0]                  voice_ready,
   input  logic [2:0]                             volume_shift,
   input  logic                                   master_mute,
   input  logic                                   clear_underrun,
   input  logic                                   audio_out_allowed,
   output logic [AUDIO_DATA_WIDTH-1:0]            left_channel_audio_out,
   output logic [AUDIO_DATA_WIDTH-1:0]            right_channel_audio_out,
   output logic                                   write_audio_out,
   output logic                                   busy,
   output logic [NUM_VOICES-1:0]                  voice_underrun,
   output logic [15:0]                            frame_count
);

   localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int EXT_W  = ACC_WIDTH - AUDIO_DATA_WIDTH;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(EXT_W + 1){1'b0}}, {(AUDIO_DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(EXT_W + 1){1'b1}}, {(AUDIO_DATA_WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATHER = 2'd1,
      ST_SCALE  = 2'd2,
      ST_WRITE  = 2'd3
   } state_t;

   // Arithmetic attenuation of the mix followed by clamping to the sample range.
   function automatic logic [AUDIO_DATA_WIDTH-1:0] scale_saturate(
      input logic signed [ACC_WIDTH-1:0] acc,
      input logic [2:0]                  shift,
      input logic                        mute
   );
      logic signed [ACC_WIDTH-1:0] mix;
      mix = acc >>> shift;
      if (mute) begin
         return {AUDIO_DATA_WIDTH{1'b0}};
      end else if (mix > SAT_MAX) begin
         return SAT_MAX[AUDIO_DATA_WIDTH-1:0];
      end else if (mix < SAT_MIN) begin
         return SAT_MIN[AUDIO_DATA_WIDTH-1:0];
      end else begin
         return mix[AUDIO_DATA_WIDTH-1:0];
      end
   endfunction

   state_t                        state_r, state_next_s;
   logic [SLOT_W-1:0]             slot_r;
   logic signed [ACC_WIDTH-1:0]   acc_r;
   logic [AUDIO_DATA_WIDTH-1:0]   sample_s;
   logic                          accept_s, miss_s, write_s, busy_s;
   logic [NUM_VOICES-1:0]         voice_ready_s, underrun_set_s, underrun_r;
   logic [AUDIO_DATA_WIDTH-1:0]   audio_r;
   logic [15:0]                   frame_count_r;

   assign sample_s = voice_sample[slot_r*AUDIO_DATA_WIDTH +: AUDIO_DATA_WIDTH];
   assign accept_s = (state_r == ST_GATHER) & voice_enable[slot_r] & voice_valid[slot_r];
   assign miss_s   = (state_r == ST_GATHER) & voice_enable[slot_r] & ~voice_valid[slot_r];

   // State register, gather slot index and accumulator.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r <= ST_IDLE;
         slot_r  <= {SLOT_W{1'b0}};
         acc_r   <= {ACC_WIDTH{1'b0}};
      end else begin
         state_r <= state_next_s;
         case (state_r)
            ST_IDLE: begin
               slot_r <= {SLOT_W{1'b0}};
               acc_r  <= {ACC_WIDTH{1'b0}};
            end
            ST_GATHER: begin
               slot_r <= slot_r + SLOT_W'(1);
               if (accept_s) begin
                  acc_r <= acc_r + {{EXT_W{sample_s[AUDIO_DATA_WIDTH-1]}}, sample_s};
               end
            end
            default: begin
               slot_r <= slot_r;
               acc_r  <= acc_r;
            end
         endcase
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (audio_out_allowed) state_next_s = ST_GATHER;
            else                   state_next_s = ST_IDLE;
         end
         ST_GATHER: begin
            if (slot_r == LAST_SLOT) state_next_s = ST_SCALE;
            else                     state_next_s = ST_GATHER;
         end
         ST_SCALE: state_next_s = ST_WRITE;
         ST_WRITE: begin
            if (audio_out_allowed) state_next_s = ST_IDLE;
            else                   state_next_s = ST_WRITE;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Per-state outputs: accept strobes, underrun set requests, write strobe, busy.
   always_comb begin
      voice_ready_s  = {NUM_VOICES{1'b0}};
      underrun_set_s = {NUM_VOICES{1'b0}};
      if (accept_s) voice_ready_s[slot_r] = 1'b1;
      else          voice_ready_s = {NUM_VOICES{1'b0}};
      if (miss_s) underrun_set_s[slot_r] = 1'b1;
      else        underrun_set_s = {NUM_VOICES{1'b0}};
      write_s = (state_r == ST_WRITE) & audio_out_allowed;
      busy_s  = (state_r != ST_IDLE);
   end

   // Output sample register and frame counter.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         audio_r       <= {AUDIO_DATA_WIDTH{1'b0}};
         frame_count_r <= 16'd0;
      end else begin
         if (state_r == ST_SCALE) begin
            audio_r <= scale_saturate(acc_r, volume_shift, master_mute);
         end
         if (write_s) begin
            frame_count_r <= frame_count_r + 16'd1;
         end
      end
   end

   // Sticky underrun flags; a new miss outranks a simultaneous clear.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         underrun_r <= {NUM_VOICES{1'b0}};
      end else begin
         underrun_r <= (clear_underrun ? {NUM_VOICES{1'b0}} : underrun_r) | underrun_set_s;
      end
   end

   assign voice_ready             = voice_ready_s;
   assign write_audio_out         = write_s;
   assign busy                    = busy_s;
   assign left_channel_audio_out  = audio_r;
   assign right_channel_audio_out = audio_r;
   assign voice_underrun          = underrun_r;
   assign frame_count             = frame_count_r;

endmodule

// File: tb/tb_audio_voice_mixer_scheduler.sv
// Randomized self-checking bench for audio_voice_mixer_scheduler against a frame-level mix model.
module tb_audio_voice_mixer_scheduler;

   localparam int NV = 4;
   localparam int AW = 21;

   logic              CLOCK_50 = 1'b0;
   logic              reset;
   logic [NV-1:0]     voice_enable, voice_valid, voice_ready, voice_underrun;
   logic [NV*AW-1:0]  voice_sample;
   logic [2:0]        volume_shift;
   logic              master_mute, clear_underrun, audio_out_allowed;
   logic [AW-1:0]     left_channel_audio_out, right_channel_audio_out;
   logic              write_audio_out, busy;
   logic [15:0]       frame_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_fc  = 16'd0;
   logic [3:0]  exp_ur  = 4'd0;

   audio_voice_mixer_scheduler dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .voice_enable(voice_enable), .voice_valid(voice_valid), .voice_sample(voice_sample),
      .voice_ready(voice_ready), .volume_shift(volume_shift), .master_mute(master_mute),
      .clear_underrun(clear_underrun), .audio_out_allowed(audio_out_allowed),
      .left_channel_audio_out(left_channel_audio_out),
      .right_channel_audio_out(right_channel_audio_out),
      .write_audio_out(write_audio_out), .busy(busy),
      .voice_underrun(voice_underrun), .frame_count(frame_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Frame result: sum of accepted voices, arithmetic shift, clamp, mute.
   function automatic int model_mix(input int s[4], input logic [3:0] en, input logic [3:0] val,
                                    input int sh, input logic mute);
      int sum = 0;
      for (int i = 0; i < NV; i++) if (en[i] && val[i]) sum += s[i];
      sum = sum >>> sh;
      if (sum > 1048575)  sum = 1048575;
      if (sum < -1048576) sum = -1048576;
      return mute ? 0 : sum;
   endfunction

   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic drive_junk(input int slot);
      for (int j = 0; j < NV; j++) begin
         if (j != slot) begin
            voice_valid[j] = 1'($urandom_range(0, 1));
            voice_sample[j*AW +: AW] = AW'($urandom);
         end
      end
   endtask

   // One complete frame starting in the current IDLE cycle; ends one cycle into the following IDLE.
   task automatic run_frame(input int s[4], input logic [3:0] en, input logic [3:0] val,
                            input int sh, input logic mute, input int hold, input int clr_slot);
      logic [AW-1:0] exp_d;
      logic [3:0]    exp_rdy;
      exp_d = AW'(model_mix(s, en, val, sh, mute));
      voice_enable = en;
      audio_out_allowed = 1'b1;
      volume_shift = 3'($urandom);
      master_mute = 1'($urandom_range(0, 1));
      drive_junk(-1);
      #1;
      n_tests++;
      if ({busy, write_audio_out, voice_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL idle_start: got %b expected 000000", {busy, write_audio_out, voice_ready});
      end
      for (int k = 0; k < NV; k++) begin
         tick;
         voice_valid[k] = val[k];
         voice_sample[k*AW +: AW] = AW'(s[k]);
         drive_junk(k);
         audio_out_allowed = 1'($urandom_range(0, 1));
         volume_shift = 3'($urandom);
         master_mute = 1'($urandom_range(0, 1));
         clear_underrun = (k == clr_slot);
         #1;
         exp_rdy = (en[k] && val[k]) ? (4'b0001 << k) : 4'b0000;
         n_tests++;
         if ({busy, write_audio_out, voice_ready} !== {1'b1, 1'b0, exp_rdy}) begin
            n_fail++;
            $display("FAIL gather_slot%0d: got %b expected %b", k,
                     {busy, write_audio_out, voice_ready}, {1'b1, 1'b0, exp_rdy});
         end
      end
      tick;
      clear_underrun = 1'b0;
      volume_shift = 3'(sh);
      master_mute = mute;
      audio_out_allowed = 1'($urandom_range(0, 1));
      drive_junk(-1);
      #1;
      n_tests++;
      if ({busy, write_audio_out, voice_ready} !== 6'b100000) begin
         n_fail++;
         $display("FAIL scale: got %b expected 100000", {busy, write_audio_out, voice_ready});
      end
      for (int w = 0; w <= hold; w++) begin
         tick;
         audio_out_allowed = (w == hold);
         volume_shift = 3'($urandom);
         master_mute = 1'($urandom_range(0, 1));
         drive_junk(-1);
         #1;
         n_tests++;
         if ({busy, write_audio_out, voice_ready, left_channel_audio_out, right_channel_audio_out,
              frame_count} !== {1'b1, (w == hold), 4'b0000, exp_d, exp_d, exp_fc}) begin
            n_fail++;
            $display("FAIL write_w%0d: got busy=%b wr=%b rdy=%b l=%0d r=%0d fc=%0d expected wr=%b l=r=%0d fc=%0d",
                     w, busy, write_audio_out, voice_ready, $signed(left_channel_audio_out),
                     $signed(right_channel_audio_out), frame_count, (w == hold), $signed(exp_d), exp_fc);
         end
      end
      exp_fc = exp_fc + 16'd1;
      if (clr_slot >= 0) begin
         exp_ur = 4'b0000;
         for (int i = clr_slot; i < NV; i++) exp_ur[i] = en[i] & ~val[i];
      end else begin
         exp_ur = exp_ur | (en & ~val);
      end
      tick;
      audio_out_allowed = 1'b0;
      drive_junk(-1);
      #1;
      n_tests++;
      if ({busy, write_audio_out, voice_ready, frame_count, voice_underrun, left_channel_audio_out}
          !== {1'b0, 1'b0, 4'b0000, exp_fc, exp_ur, exp_d}) begin
         n_fail++;
         $display("FAIL frame_end: got busy=%b wr=%b fc=%0d ur=%b l=%0d expected fc=%0d ur=%b l=%0d",
                  busy, write_audio_out, frame_count, voice_underrun, $signed(left_channel_audio_out),
                  exp_fc, exp_ur, $signed(exp_d));
      end
   endtask

   task automatic check_zero_state(input string name);
      n_tests++;
      if ({busy, write_audio_out, voice_ready, voice_underrun, frame_count,
           left_channel_audio_out, right_channel_audio_out} !== {2'b00, 8'h00, 16'd0, {(2*AW){1'b0}}}) begin
         n_fail++;
         $display("FAIL %s: got busy=%b wr=%b rdy=%b ur=%b fc=%0d l=%h r=%h expected all zero", name,
                  busy, write_audio_out, voice_ready, voice_underrun, frame_count,
                  left_channel_audio_out, right_channel_audio_out);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) tick;
      check_zero_state("reset_values");
      reset = 1'b0;
      exp_fc = 16'd0;
      exp_ur = 4'd0;
   endtask

   task automatic test_idle_wait;
      audio_out_allowed = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         n_tests++;
         if ({busy, write_audio_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_wait: got %b expected 00", {busy, write_audio_out});
         end
      end
   endtask

   task automatic test_basic_mix;
      int s[4];
      s = '{1000, 2000, -500, 250};
      run_frame(s, 4'hF, 4'hF, 0, 1'b0, 0, -1);
   endtask

   task automatic test_saturation;
      int s[4];
      s = '{1048575, 1048575, 1048575, 1048575};
      run_frame(s, 4'hF, 4'hF, 0, 1'b0, 0, -1);
      run_frame(s, 4'hF, 4'hF, 2, 1'b0, 0, -1);
      s = '{-1048576, -1048576, -1048576, -1048576};
      run_frame(s, 4'hF, 4'hF, 0, 1'b0, 0, -1);
   endtask

   task automatic test_underrun;
      int s[4];
      s = '{100, 200, 300, 400};
      run_frame(s, 4'hF, 4'b1011, 0, 1'b0, 0, -1);
      clear_underrun = 1'b1;
      tick;
      clear_underrun = 1'b0;
      exp_ur = 4'b0000;
      n_tests++;
      if (voice_underrun !== 4'b0000) begin
         n_fail++;
         $display("FAIL underrun_clear: got %b expected 0000", voice_underrun);
      end
      run_frame(s, 4'b1011, 4'b1011, 1, 1'b0, 0, -1);
      run_frame(s, 4'hF, 4'b1011, 0, 1'b0, 0, -1);
      run_frame(s, 4'hF, 4'b0111, 0, 1'b0, 0, 3);
   endtask

   task automatic test_hold;
      int s[4];
      s = '{-7000, 12345, 3, -99};
      run_frame(s, 4'hF, 4'hF, 1, 1'b0, 20, -1);
   endtask

   task automatic test_mute;
      int s[4];
      s = '{5000, 6000, 7000, 8000};
      run_frame(s, 4'hF, 4'hF, 0, 1'b1, 0, -1);
      run_frame(s, 4'h0, 4'hF, 0, 1'b0, 0, -1);
   endtask

   task automatic test_reset_mid_frame;
      int s[4];
      voice_enable = 4'hF;
      voice_valid = 4'hF;
      audio_out_allowed = 1'b1;
      tick;
      tick;
      reset = 1'b1;
      audio_out_allowed = 1'b0;
      tick;
      reset = 1'b0;
      exp_fc = 16'd0;
      exp_ur = 4'd0;
      check_zero_state("reset_mid_frame");
      for (int c = 0; c < 8; c++) begin
         tick;
         n_tests++;
         if ({busy, write_audio_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 00", {busy, write_audio_out});
         end
      end
      s = '{10, 20, 30, 40};
      run_frame(s, 4'hF, 4'hF, 0, 1'b0, 0, -1);
   endtask

   task automatic test_random(input int frames);
      int s[4];
      for (int f = 0; f < frames; f++) begin
         for (int i = 0; i < NV; i++) s[i] = int'($urandom_range(0, 2097151)) - 1048576;
         run_frame(s, 4'($urandom), 4'($urandom), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1);
      end
   endtask

   initial begin
      reset = 1'b1;
      voice_enable = 4'h0;
      voice_valid = 4'h0;
      voice_sample = {(NV*AW){1'b0}};
      volume_shift = 3'd0;
      master_mute = 1'b0;
      clear_underrun = 1'b0;
      audio_out_allowed = 1'b0;
      test_reset;
      test_idle_wait;
      test_basic_mix;
      test_saturation;
      test_underrun;
      test_hold;
      test_mute;
      test_reset_mid_frame;
      test_idle_wait;
      test_random(60);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
